// File: rtl/systolic_drain.sv
// Drain stage under the bottom PE row. Each column is deskewed by its own delay
// line, the aligned row goes into a first-word-fall-through FIFO, and rows are
// presented over valid/ready with a row index.

// Per-column deskew delay line. Valid and data travel together through STAGES flops.
module systolic_drain_lane #(
  parameter int STAGES = 1,
  parameter int W      = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         vld,
  input  logic [W-1:0] data,
  output logic         dsk_vld,
  output logic [W-1:0] dsk_data
);

  if (STAGES == 0) begin : g_pass
    assign dsk_vld  = vld;
    assign dsk_data = data;
  end else begin : g_dly
    logic [STAGES:1]        vld_pipe;
    logic [STAGES:1][W-1:0] dat_pipe;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_pipe <= '0;
        dat_pipe <= '0;
      end else if (clear) begin
        vld_pipe <= '0;
        dat_pipe <= '0;
      end else begin
        vld_pipe[1] <= vld;
        dat_pipe[1] <= data;
        for (int i = 2; i <= STAGES; i++) begin
          vld_pipe[i] <= vld_pipe[i-1];
          dat_pipe[i] <= dat_pipe[i-1];
        end
      end
    end

    assign dsk_vld  = vld_pipe[STAGES];
    assign dsk_data = dat_pipe[STAGES];
  end

endmodule

module systolic_drain #(
  parameter int N_COLS     = 2,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int ROW_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic [N_COLS-1:0]            col_valid_in,
  input  logic [N_COLS*DATA_WIDTH-1:0] col_psum_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_COLS*DATA_WIDTH-1:0] out_data,
  output logic [ROW_W-1:0]             out_row,
  output logic [$clog2(DEPTH):0]       fifo_count,
  output logic                         overflow,
  output logic                         misalign
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ROW_W-1:0]                  row;
    logic [N_COLS-1:0][DATA_WIDTH-1:0] data;
  } ent_t;

  logic [N_COLS-1:0]                  dsk_vld;
  logic [N_COLS-1:0][DATA_WIDTH-1:0]  dsk_data;

  // Column c waits N_COLS-1-c cycles so it lines up with the last column.
  for (genvar c = 0; c < N_COLS; c++) begin : g_lane
    systolic_drain_lane #(
      .STAGES(N_COLS-1-c),
      .W     (DATA_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .vld     (col_valid_in[c]),
      .data    (col_psum_in[c*DATA_WIDTH +: DATA_WIDTH]),
      .dsk_vld (dsk_vld[c]),
      .dsk_data(dsk_data[c])
    );
  end

  logic             all_v, any_v, full, pop, push_ok, drop;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [ROW_W-1:0] wr_row;
  ent_t             mem [DEPTH];
  ent_t             head;

  assign all_v   = &dsk_vld;
  assign any_v   = |dsk_vld;
  assign full    = (count == FULL_CNT);
  assign pop     = out_valid && out_ready;
  // A pop at the same edge frees the slot, so a full FIFO can still accept.
  assign push_ok = all_v && (!full || pop);
  assign drop    = all_v && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wr_row   <= '0;
      overflow <= 1'b0;
      misalign <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wr_row   <= '0;
      overflow <= 1'b0;
      misalign <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        wr_row <= wr_row + ROW_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)      count <= count + CNT_W'(1);
      else if (!push_ok && pop) count <= count - CNT_W'(1);
      if (drop)                 overflow <= 1'b1;
      if (any_v && !all_v)      misalign <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy is governed by count and the pointers.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= '{row: wr_row, data: dsk_data};
  end

  assign head       = mem[rd_ptr];
  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? head.data : '0;
  assign out_row    = out_valid ? head.row  : '0;
  assign fifo_count = count;

endmodule

// File: tb/tb_systolic_drain.sv
// Randomized and directed bench for systolic_drain, checked every cycle against
// a queue-based model of the skewed-column / FIFO behaviour.
module tb_systolic_drain;
  localparam int N  = 2;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int RW = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clear = 1'b0;
  logic             out_ready = 1'b0;
  logic [N-1:0]     col_valid_in = '0;
  logic [N*W-1:0]   col_psum_in = '0;
  logic             out_valid;
  logic [N*W-1:0]   out_data;
  logic [RW-1:0]    out_row;
  logic [$clog2(D):0] fifo_count;
  logic             overflow, misalign;

  always #5 clk = ~clk;

  systolic_drain #(.N_COLS(N), .DATA_WIDTH(W), .DEPTH(D), .ROW_W(RW)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .col_valid_in(col_valid_in), .col_psum_in(col_psum_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row),
    .fifo_count(fifo_count), .overflow(overflow), .misalign(misalign)
  );

  typedef struct { logic [N*W-1:0] d; logic [RW-1:0] r; } ent_t;
  ent_t          q[$];
  logic [RW-1:0] m_row;
  bit            m_ovf, m_mis;
  // hv/hd[c][a]: what column c received a cycles ago (a >= 1)
  bit            hv [N][N];
  logic [W-1:0]  hd [N][N];
  // fv/fd[c][k]: what column c will receive k cycles from now
  bit            fv [N][N];
  logic [W-1:0]  fd [N][N];

  int vectors = 0, miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_row = '0; m_ovf = 0; m_mis = 0;
    for (int c = 0; c < N; c++)
      for (int a = 0; a < N; a++) begin hv[c][a] = 0; hd[c][a] = '0; end
  endtask

  task automatic clear_future();
    for (int c = 0; c < N; c++)
      for (int k = 0; k < N; k++) begin fv[c][k] = 0; fd[c][k] = '0; end
  endtask

  task automatic compare_all();
    bit v;
    v = (q.size() != 0);
    chk("out_valid", out_valid, v);
    chk("fifo_count", fifo_count, q.size());
    chk("out_data", out_data, v ? q[0].d : '0);
    if (v) chk("out_row", out_row, q[0].r);
    chk("overflow", overflow, m_ovf);
    chk("misalign", misalign, m_mis);
  endtask

  // Applies one clock edge to the model using the inputs that were just presented.
  task automatic model_edge();
    bit [N-1:0] av;
    logic [N*W-1:0] ad;
    bit all_v, any_v, pop;
    int sz;
    if (clear) begin
      model_reset();
      return;
    end
    for (int c = 0; c < N; c++) begin
      // column c's row r arrived c cycles after column 0; realign to the last column
      av[c]          = (c == N-1) ? fv[c][0] : hv[c][N-1-c];
      ad[c*W +: W]   = (c == N-1) ? fd[c][0] : hd[c][N-1-c];
    end
    all_v = &av;
    any_v = |av;
    sz  = q.size();
    pop = (sz != 0) && out_ready;
    if (pop) void'(q.pop_front());
    if (all_v) begin
      if (sz < D || pop) begin
        q.push_back('{d: ad, r: m_row});
        m_row++;
      end else m_ovf = 1;
    end
    if (any_v && !all_v) m_mis = 1;
    for (int c = 0; c < N; c++) begin
      for (int a = N-1; a >= 2; a--) begin hv[c][a] = hv[c][a-1]; hd[c][a] = hd[c][a-1]; end
      if (N > 1) begin hv[c][1] = fv[c][0]; hd[c][1] = fd[c][0]; end
    end
  endtask

  task automatic step();
    for (int c = 0; c < N; c++) begin
      col_valid_in[c]         = fv[c][0];
      col_psum_in[c*W +: W]   = fv[c][0] ? fd[c][0] : W'($urandom);
    end
    #4;
    compare_all();
    @(posedge clk);
    #1;
    model_edge();
    for (int c = 0; c < N; c++) begin
      for (int k = 0; k < N-1; k++) begin fv[c][k] = fv[c][k+1]; fd[c][k] = fd[c][k+1]; end
      fv[c][N-1] = 0; fd[c][N-1] = '0;
    end
  endtask

  // Row enters column 0 in the upcoming step; column c sees it c steps later.
  task automatic inject(input bit [N-1:0] mask, input logic [N*W-1:0] d);
    for (int c = 0; c < N; c++)
      if (mask[c]) begin fv[c][c] = 1; fd[c][c] = d[c*W +: W]; end
  endtask

  function automatic logic [N*W-1:0] rnd_row();
    logic [N*W-1:0] r;
    for (int c = 0; c < N; c++) r[c*W +: W] = W'($urandom);
    return r;
  endfunction

  task automatic clr();
    clear = 1; step(); clear = 0;
  endtask

  initial begin
    model_reset();
    clear_future();
    #2;
    chk("reset out_valid", out_valid, 0);
    chk("reset fifo_count", fifo_count, 0);
    chk("reset out_row", out_row, 0);
    chk("reset out_data", out_data, 0);
    @(posedge clk); #1;
    rst = 1;

    // single row
    out_ready = 1;
    inject('1, {16'hFF80, 16'h0100});
    step(); step();
    chk("single out_valid", out_valid, 1);
    chk("single out_data", out_data, 32'hFF80_0100);
    chk("single out_row", out_row, 0);
    step();
    chk("single drop", out_valid, 0);

    // burst of 4 with ready low, then drain
    clr(); out_ready = 0;
    for (int i = 0; i < 4; i++) begin inject('1, rnd_row()); step(); end
    for (int i = 0; i < N-1; i++) step();
    chk("burst4 count", fifo_count, 4);
    chk("burst4 overflow", overflow, 0);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin chk("burst4 row", out_row, i); step(); end
    chk("burst4 empty", fifo_count, 0);

    // burst of 5: fifth row dropped
    clr(); out_ready = 0;
    for (int i = 0; i < 5; i++) begin inject('1, rnd_row()); step(); end
    for (int i = 0; i < N-1; i++) step();
    chk("burst5 overflow", overflow, 1);
    chk("burst5 count", fifo_count, 4);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin chk("burst5 row", out_row, i); step(); end
    chk("burst5 empty", out_valid, 0);
    chk("burst5 sticky", overflow, 1);

    // full FIFO, fifth row pushed in the same cycle as a pop
    clr(); out_ready = 0;
    for (int i = 0; i < 5; i++) begin inject('1, rnd_row()); step(); end
    for (int i = 0; i < N-2; i++) step();
    out_ready = 1; step(); out_ready = 0;
    chk("pushpop overflow", overflow, 0);
    chk("pushpop count", fifo_count, 4);
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin chk("pushpop row", out_row, i); step(); end

    // misaligned row
    clr();
    inject(1, rnd_row());
    for (int i = 0; i < N; i++) step();
    chk("misalign set", misalign, 1);
    chk("misalign count", fifo_count, 0);
    clr();
    chk("clear misalign", misalign, 0);
    chk("clear overflow", overflow, 0);

    // asynchronous reset with two rows buffered and one in flight
    clr(); out_ready = 0;
    for (int i = 0; i < 3; i++) begin inject('1, rnd_row()); step(); end
    chk("prereset count", fifo_count, 2);
    #3 rst = 0;
    #1;
    chk("async out_valid", out_valid, 0);
    chk("async fifo_count", fifo_count, 0);
    model_reset(); clear_future();
    col_valid_in = '0;
    @(posedge clk); #1;
    rst = 1;
    inject('1, rnd_row());
    for (int i = 0; i < N; i++) step();
    chk("post reset valid", out_valid, 1);
    chk("post reset row", out_row, 0);

    // randomized traffic
    clr();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) != 0)
        inject(($urandom_range(0, 19) == 0) ? N'($urandom) : '1, rnd_row());
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 99) == 0);
      step();
      clear = 0;
    end
    out_ready = 1;
    for (int i = 0; i < D + N + 2; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Receive end of the PE psum chain: sits below the bottom PE row and captures each column's psum_out/pe_valid_out stream.
- Columns arrive diagonally skewed, one cycle per column. The block deskews them into row-aligned vectors and buffers them in a FIFO.
- Results are presented downstream over a valid/ready handshake with a row index.
- PEs cannot stall, so overflow is flagged rather than back-pressured.

Parameters:
- N_COLS, 2, number of systolic columns drained (>=1).
- DATA_WIDTH, 16, psum width per column (Q8.8 signed fixed-point, passed through unmodified).
- DEPTH, 4, FIFO depth in row vectors (power of 2, >=2).
- ROW_W, 8, width of the row index counter.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- clear  input  1  synchronous flush of delay lines, FIFO, row counter and sticky flags.
- col_valid_in  input  N_COLS  per-column pe_valid_out from the bottom PE row.
- col_psum_in  input  N_COLS*DATA_WIDTH  per-column psum_out; column c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- out_valid  output  1  aligned row available.
- out_ready  input  1  downstream accepts the row.
- out_data  output  N_COLS*DATA_WIDTH  aligned row, same column packing as the input.
- out_row  output  ROW_W  index of the row on out_data.
- fifo_count  output  clog2(DEPTH)+1  occupied entries.
- overflow  output  1  sticky: an aligned row was dropped because the FIFO was full.
- misalign  output  1  sticky: deskewed valids disagreed.

Behaviour:
- Reset (rst=0, asynchronous): delay lines, FIFO pointers, count, write-side row counter, overflow and misalign all go to 0.
  - Outputs: out_valid=0, out_data=0, out_row=0, fifo_count=0.
- Deskew:
  - Column c (valid and data together) passes through N_COLS-1-c register stages.
  - Column N_COLS-1 is used combinationally with zero stages.
  - Input protocol: row r enters column c exactly c cycles after it enters column 0.
- Aligned vector: the AND of all deskewed valids.
  - If column 0 valid is high in cycle k, the aligned vector is valid in cycle k+N_COLS-1.
  - The row is pushed at the clock edge ending that cycle.
- Misalign: any deskewed valid high while not all are high sets misalign (sticky). Nothing is pushed in that cycle.
- FIFO:
  - DEPTH entries; each entry holds the data vector plus its row index. Row index = write counter, incremented per push, wrapping modulo 2^ROW_W.
  - First-word fall-through: out_valid = (count != 0), and out_data/out_row show the head entry.
  - Load-to-use latency: column 0 valid in cycle k gives out_valid high in cycle k+N_COLS when the FIFO was empty.
- Pop: out_valid && out_ready at the edge.
- Push while full with no pop: the row is dropped, overflow is set (sticky), and count, contents and row counter are unchanged.
- Push and pop in the same cycle when full: both occur, count stays DEPTH, overflow is not set.
- Push and pop when empty: only the push occurs; the row becomes visible the next cycle (no bypass).
- out_data holds its value while out_valid=1 and out_ready=0. out_data is don't-care when out_valid=0; the implementation drives 0.
- clear=1: at the next edge, everything is reset exactly as rst does. clear takes priority over a simultaneous push or pop.
- Reset mid-stream: partially deskewed rows are discarded. The first row after reset gets out_row=0.
- Pointers are log2(DEPTH) bits and wrap naturally. count is tracked separately to distinguish full from empty.
- No arithmetic: data is carried bit-exact.

Test Plan:
- Single row, N_COLS=2, out_ready=1:
  - Stimulus: col0 valid with 0x0100 in cycle 0; col1 valid with 0xFF80 in cycle 1.
  - Response: out_valid=1 in cycle 2 with out_data={0xFF80,0x0100} and out_row=0; it drops next cycle.
- Burst of 4 skewed rows, out_ready=0:
  - Response: fifo_count reaches 4, overflow=0.
  - Raising out_ready drains rows 0..3 in order with out_row=0,1,2,3 and correct data.
- Burst of 5 rows, out_ready=0, DEPTH=4:
  - Response: overflow=1 and stays set.
  - Drain yields exactly rows 0..3; row index 4 is never emitted.
- FIFO full, 5th row arrives while out_ready=1 in that cycle:
  - Response: overflow=0, count stays 4.
  - Subsequent drain emits rows 1..4.
- Misaligned input: col0 valid in cycle 0, col1 valid not asserted in cycle 1.
  - Response: misalign=1, fifo_count stays 0.
  - Pulsing clear returns misalign and overflow to 0.
- Reset mid-burst:
  - Stimulus: drive rst=0 asynchronously between clock edges, with 2 rows buffered and 1 in flight.
  - Response: out_valid=0 and fifo_count=0 immediately.
  - The next full row emitted after release has out_row=0.
